// File: rtl/xor_check_monitor.sv
// xor_check_monitor
//   Consumes checked XOR-parity samples (y = a ^ b, y == 1 means pass). It keeps
//   saturating pass/fail totals and the current consecutive-fail run length, and
//   escalates a severity state OK -> WARN -> ERROR -> FATAL. FATAL halts the
//   stream with a sticky flag that only rst removes.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   in_valid  a y sample is presented this cycle
//   in_ready  monitor accepts samples (low once halted)
//   y         checked result: 1 = pass, 0 = fail
//   clr       synchronous clear of counters and of WARN/ERROR severity
//   sev       severity: 0 OK, 1 WARN, 2 ERROR, 3 FATAL
//   pass_cnt  saturating count of accepted passes
//   fail_cnt  saturating count of accepted fails
//   run_len   saturating length of the current consecutive-fail run
//   halt      sticky, set on FATAL entry
//
// HARD_ERR selects $error (1) or $warning (0) for ERROR/FATAL entry messages,
// so a directed run can walk through FATAL and still inspect the state.
module xor_check_monitor #(
  parameter int CNT_W    = 8,
  parameter int WARN_TH  = 2,
  parameter int ERR_TH   = 4,
  parameter int FATAL_TH = 6,
  parameter bit HARD_ERR = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             y,
  input  logic             clr,
  output logic [1:0]       sev,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] run_len,
  output logic             halt
);

  if (!(WARN_TH < ERR_TH && ERR_TH < FATAL_TH && FATAL_TH <= (2 ** CNT_W) - 1)) begin : g_param_check
    $fatal(1, "xor_check_monitor: need WARN_TH < ERR_TH < FATAL_TH <= 2**CNT_W-1");
  end

  typedef enum logic [1:0] {
    SEV_OK    = 2'd0,
    SEV_WARN  = 2'd1,
    SEV_ERR   = 2'd2,
    SEV_FATAL = 2'd3
  } sev_t;

  localparam logic [CNT_W:0] WARN_R  = (CNT_W + 1)'(WARN_TH);
  localparam logic [CNT_W:0] ERR_R   = (CNT_W + 1)'(ERR_TH);
  localparam logic [CNT_W:0] FATAL_R = (CNT_W + 1)'(FATAL_TH);

  sev_t             sev_q, sev_d;
  logic [CNT_W-1:0] pass_q, pass_d;
  logic [CNT_W-1:0] fail_q, fail_d;
  logic [CNT_W-1:0] run_q, run_d;
  logic             halt_q, halt_d;
  logic [CNT_W:0]   run_inc;
  logic             accept;

  assign in_ready = ~halt_q;
  assign accept   = (in_valid === 1'b1) && !halt_q;
  assign run_inc  = {1'b0, run_q} + 1'b1;

  always_comb begin
    sev_d  = sev_q;
    pass_d = pass_q;
    fail_d = fail_q;
    run_d  = run_q;
    halt_d = halt_q;
    // Once halted everything freezes, clr included; only rst leaves FATAL.
    if (!halt_q) begin
      if (clr) begin
        pass_d = '0;
        fail_d = '0;
        run_d  = '0;
        sev_d  = SEV_OK;
      end else if (accept) begin
        if (y) begin
          pass_d = (pass_q == '1) ? pass_q : pass_q + 1'b1;
          run_d  = '0;
          if (sev_q == SEV_WARN) sev_d = SEV_OK;
        end else begin
          fail_d = (fail_q == '1) ? fail_q : fail_q + 1'b1;
          run_d  = (run_q == '1) ? run_q : run_inc[CNT_W-1:0];
          // Escalation compares the post-increment run in CNT_W+1 bits.
          if (run_inc >= FATAL_R) begin
            sev_d  = SEV_FATAL;
            halt_d = 1'b1;
          end else if (run_inc >= ERR_R) begin
            sev_d = SEV_ERR;
          end else if (run_inc >= WARN_R && sev_q == SEV_OK) begin
            sev_d = SEV_WARN;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sev_q  <= SEV_OK;
      pass_q <= '0;
      fail_q <= '0;
      run_q  <= '0;
      halt_q <= 1'b0;
    end else begin
      sev_q  <= sev_d;
      pass_q <= pass_d;
      fail_q <= fail_d;
      run_q  <= run_d;
      halt_q <= halt_d;

      assert (!(in_ready && $isunknown(in_valid)))
        else $error("in_valid unknown while in_ready run_len=%0d t=%0t", run_q, $time);

      if (accept && !clr) begin
        assert (y || sev_q != SEV_OK)
          else $info("fail in OK run_len=%0d t=%0t", run_d, $time);
        assert (!(sev_d == SEV_WARN && sev_q != SEV_WARN))
          else $warning("WARN entered run_len=%0d t=%0t", run_d, $time);
        assert (!(sev_d == SEV_ERR && sev_q != SEV_ERR))
          else if (HARD_ERR) $error("ERROR entered run_len=%0d t=%0t", run_d, $time);
          else $warning("ERROR entered run_len=%0d t=%0t", run_d, $time);
        assert (!(sev_d == SEV_FATAL && sev_q != SEV_FATAL))
          else if (HARD_ERR) $error("FATAL run_len=%0d t=%0t", run_d, $time);
          else $warning("FATAL run_len=%0d t=%0t", run_d, $time);
      end
    end
  end

  assign sev      = sev_q;
  assign pass_cnt = pass_q;
  assign fail_cnt = fail_q;
  assign run_len  = run_q;
  assign halt     = halt_q;

endmodule

// File: tb/tb_xor_check_monitor.sv
// Directed scoreboard bench: each step queues the hand-computed output snapshot;
// a monitor pops and compares every queued snapshot when sampling is triggered.
module tb_xor_check_monitor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic v0 = 1'b0, y0 = 1'b0, c0 = 1'b0;
  logic v1 = 1'b0, y1 = 1'b0, c1 = 1'b0;

  logic       rdy0, halt0;
  logic [1:0] sev0;
  logic [7:0] pc0, fc0, rl0;
  logic       rdy1, halt1;
  logic [1:0] sev1;
  logic [2:0] pc1, fc1, rl1;

  always #5 clk = ~clk;

  xor_check_monitor #(.CNT_W(8), .WARN_TH(2), .ERR_TH(4), .FATAL_TH(6), .HARD_ERR(1'b0)) dut (
    .clk(clk), .rst(rst), .in_valid(v0), .in_ready(rdy0), .y(y0), .clr(c0),
    .sev(sev0), .pass_cnt(pc0), .fail_cnt(fc0), .run_len(rl0), .halt(halt0)
  );

  xor_check_monitor #(.CNT_W(3), .WARN_TH(2), .ERR_TH(4), .FATAL_TH(6), .HARD_ERR(1'b0)) dut3 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1), .y(y1), .clr(c1),
    .sev(sev1), .pass_cnt(pc1), .fail_cnt(fc1), .run_len(rl1), .halt(halt1)
  );

  typedef struct {
    int         id;
    bit         sel;
    logic [1:0] sev;
    logic [7:0] pc, fc, rl;
    logic       halt, rdy;
  } exp_t;

  exp_t q[$];
  int   npass = 0;
  int   ntotal = 0;
  int   nid = 0;
  event smp;

  always @(posedge clk) begin
    #2 ->smp;
  end

  initial begin : monitor
    exp_t e;
    logic [1:0] s;
    logic [7:0] p, f, r;
    logic h, rd;
    forever begin
      @(smp);
      while (q.size() > 0) begin
        e = q.pop_front();
        if (e.sel) begin
          s = sev1; p = {5'd0, pc1}; f = {5'd0, fc1}; r = {5'd0, rl1}; h = halt1; rd = rdy1;
        end else begin
          s = sev0; p = pc0; f = fc0; r = rl0; h = halt0; rd = rdy0;
        end
        ntotal++;
        if (s === e.sev && p === e.pc && f === e.fc && r === e.rl && h === e.halt && rd === e.rdy)
          npass++;
        else
          $display("FAIL chk%0d dut%0d: got sev=%0d pass=%0d fail=%0d run=%0d halt=%0b rdy=%0b, expected sev=%0d pass=%0d fail=%0d run=%0d halt=%0b rdy=%0b",
                   e.id, e.sel, s, p, f, r, h, rd, e.sev, e.pc, e.fc, e.rl, e.halt, e.rdy);
      end
    end
  end

  function automatic exp_t mk(bit sel, int s, int p, int f, int r, bit h, bit rd);
    exp_t e;
    e.id = nid; e.sel = sel; e.sev = 2'(s);
    e.pc = 8'(p); e.fc = 8'(f); e.rl = 8'(r); e.halt = h; e.rdy = rd;
    return e;
  endfunction

  // One clock of stimulus on the selected DUT, expected snapshot after the edge.
  task automatic step(input bit sel, input bit v, input bit yy, input bit c, input exp_t e);
    @(negedge clk);
    v0 = sel ? 1'b0 : v; y0 = sel ? 1'b0 : yy; c0 = sel ? 1'b0 : c;
    v1 = sel ? v : 1'b0; y1 = sel ? yy : 1'b0; c1 = sel ? c : 1'b0;
    @(posedge clk);
    q.push_back(e);
    nid++;
  endtask

  // Snapshot checked immediately, between clock edges.
  task automatic check_now(input exp_t e);
    q.push_back(e);
    nid++;
    ->smp;
    #1;
  endtask

  initial begin : stim
    #1;
    check_now(mk(0, 0, 0, 0, 0, 0, 1));
    check_now(mk(1, 0, 0, 0, 0, 0, 1));
    @(negedge clk);
    rst = 1'b0;

    // three passes
    step(0, 1, 1, 0, mk(0, 0, 1, 0, 0, 0, 1));
    step(0, 1, 1, 0, mk(0, 0, 2, 0, 0, 0, 1));
    step(0, 1, 1, 0, mk(0, 0, 3, 0, 0, 0, 1));
    // fail, fail, pass: WARN then back to OK
    step(0, 1, 0, 0, mk(0, 0, 3, 1, 1, 0, 1));
    step(0, 1, 0, 0, mk(0, 1, 3, 2, 2, 0, 1));
    step(0, 1, 1, 0, mk(0, 0, 4, 2, 0, 0, 1));
    // idle cycle: no change even with y low
    step(0, 0, 0, 0, mk(0, 0, 4, 2, 0, 0, 1));
    // four fails reach ERROR, which a pass does not clear
    step(0, 1, 0, 0, mk(0, 0, 4, 3, 1, 0, 1));
    step(0, 1, 0, 0, mk(0, 1, 4, 4, 2, 0, 1));
    step(0, 1, 0, 0, mk(0, 1, 4, 5, 3, 0, 1));
    step(0, 1, 0, 0, mk(0, 2, 4, 6, 4, 0, 1));
    step(0, 1, 1, 0, mk(0, 2, 5, 6, 0, 0, 1));
    step(0, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 1));
    // six fails reach FATAL and halt
    step(0, 1, 0, 0, mk(0, 0, 0, 1, 1, 0, 1));
    step(0, 1, 0, 0, mk(0, 1, 0, 2, 2, 0, 1));
    step(0, 1, 0, 0, mk(0, 1, 0, 3, 3, 0, 1));
    step(0, 1, 0, 0, mk(0, 2, 0, 4, 4, 0, 1));
    step(0, 1, 0, 0, mk(0, 2, 0, 5, 5, 0, 1));
    step(0, 1, 0, 0, mk(0, 3, 0, 6, 6, 1, 0));
    step(0, 1, 0, 0, mk(0, 3, 0, 6, 6, 1, 0));
    step(0, 0, 0, 1, mk(0, 3, 0, 6, 6, 1, 0));
    step(0, 0, 0, 0, mk(0, 3, 0, 6, 6, 1, 0));
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_now(mk(0, 0, 0, 0, 0, 0, 1));
    @(negedge clk);
    rst = 1'b0;

    // CNT_W=3 instance: pass counter saturates at 7
    for (int i = 1; i <= 9; i++)
      step(1, 1, 1, 0, mk(1, 0, (i > 7) ? 7 : i, 0, 0, 0, 1));
    step(1, 1, 0, 0, mk(1, 0, 7, 1, 1, 0, 1));
    // clr with a valid sample: cleared, sample dropped
    step(1, 1, 1, 1, mk(1, 0, 0, 0, 0, 0, 1));
    step(1, 1, 0, 1, mk(1, 0, 0, 0, 0, 0, 1));
    step(1, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 1));

    // asynchronous reset between edges during a fail run
    step(0, 1, 0, 0, mk(0, 0, 0, 1, 1, 0, 1));
    step(0, 1, 0, 0, mk(0, 1, 0, 2, 2, 0, 1));
    step(0, 1, 0, 0, mk(0, 1, 0, 3, 3, 0, 1));
    @(negedge clk);
    v0 = 1'b0;
    rst = 1'b1;
    #1;
    check_now(mk(0, 0, 0, 0, 0, 0, 1));
    @(negedge clk);
    rst = 1'b0;
    step(0, 1, 1, 0, mk(0, 0, 1, 0, 0, 0, 1));
    step(0, 0, 0, 0, mk(0, 0, 1, 0, 0, 0, 1));

    repeat (4) @(posedge clk);
    #3;
    if (q.size() != 0) begin
      ntotal++;
      $display("FAIL drain: %0d snapshots left unchecked, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
